// File: rtl/bus_writer_pkg.sv
// Shared select-code definitions for the register file bus.
// Used by both the bus writer and the bus read multiplexer.
package bus_writer_pkg;

    typedef enum logic [3:0] {
        SEL_NONE = 4'd0,
        SEL_AR   = 4'd1,
        SEL_PC   = 4'd2,
        SEL_DR   = 4'd3,
        SEL_R    = 4'd4,
        SEL_AC   = 4'd5,
        SEL_TR   = 4'd6,
        SEL_R1   = 4'd7,
        SEL_R2   = 4'd8,
        SEL_RI   = 4'd9,
        SEL_RJ   = 4'd10,
        SEL_RK   = 4'd11,
        SEL_DM   = 4'd12
    } sel_e;

    localparam logic [3:0] SEL_LAST = 4'd12;

    function automatic logic sel_illegal(input logic [3:0] code);
        return code > SEL_LAST;
    endfunction

endpackage

// File: rtl/bus_writer_gp_reg.sv
// General-purpose register: synchronous clear, load, increment.
// Load wins over increment when both are asserted.
module gp_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         inc_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end else if (inc_i) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bus_writer.sv
// Bus writer: loads/increments the CPU register file from the shared bus,
// issues data-memory write strobes and flags illegal select codes.
module bus_writer
    import bus_writer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [3:0]        write_en,
    input  logic [3:0]        inc_en,
    output logic [REG_W-1:0]  ar,
    output logic [REG_W-1:0]  pc,
    output logic [REG_W-1:0]  dr,
    output logic [REG_W-1:0]  r,
    output logic [REG_W-1:0]  r1,
    output logic [REG_W-1:0]  r2,
    output logic [REG_W-1:0]  ri,
    output logic [REG_W-1:0]  rj,
    output logic [REG_W-1:0]  rk,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] tr,
    output logic              dm_we,
    output logic [REG_W-1:0]  dm_wdata,
    output logic              code_err
);

    logic [REG_W-1:0] bus_lo;
    logic             dm_we_q;
    logic             dm_we_d;
    logic [REG_W-1:0] dm_wdata_q;
    logic [REG_W-1:0] dm_wdata_d;
    logic             code_err_q;
    logic             code_err_d;

    assign bus_lo = bus_in[REG_W-1:0];

    // ar, dr and r have no increment path
    gp_reg #(.W(REG_W)) u_ar (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_AR), .inc_i(1'b0),
        .d_i(bus_lo), .q_o(ar)
    );

    gp_reg #(.W(REG_W)) u_pc (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_PC), .inc_i(inc_en == SEL_PC),
        .d_i(bus_lo), .q_o(pc)
    );

    gp_reg #(.W(REG_W)) u_dr (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_DR), .inc_i(1'b0),
        .d_i(bus_lo), .q_o(dr)
    );

    gp_reg #(.W(REG_W)) u_r (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_R), .inc_i(1'b0),
        .d_i(bus_lo), .q_o(r)
    );

    gp_reg #(.W(DATA_W)) u_ac (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_AC), .inc_i(inc_en == SEL_AC),
        .d_i(bus_in), .q_o(ac)
    );

    gp_reg #(.W(DATA_W)) u_tr (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_TR), .inc_i(inc_en == SEL_TR),
        .d_i(bus_in), .q_o(tr)
    );

    gp_reg #(.W(REG_W)) u_r1 (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_R1), .inc_i(inc_en == SEL_R1),
        .d_i(bus_lo), .q_o(r1)
    );

    gp_reg #(.W(REG_W)) u_r2 (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_R2), .inc_i(inc_en == SEL_R2),
        .d_i(bus_lo), .q_o(r2)
    );

    gp_reg #(.W(REG_W)) u_ri (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_RI), .inc_i(inc_en == SEL_RI),
        .d_i(bus_lo), .q_o(ri)
    );

    gp_reg #(.W(REG_W)) u_rj (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_RJ), .inc_i(inc_en == SEL_RJ),
        .d_i(bus_lo), .q_o(rj)
    );

    gp_reg #(.W(REG_W)) u_rk (
        .clk_i(clk), .clr_i(rst),
        .ld_i(write_en == SEL_RK), .inc_i(inc_en == SEL_RK),
        .d_i(bus_lo), .q_o(rk)
    );

    always_comb begin
        dm_we_d    = (write_en == SEL_DM);
        dm_wdata_d = dm_we_d ? bus_lo : dm_wdata_q;
        code_err_d = code_err_q | sel_illegal(write_en);
    end

    // dm_we is a one-cycle pulse; reset drops a pending strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_we_q    <= 1'b0;
            dm_wdata_q <= '0;
            code_err_q <= 1'b0;
        end else begin
            dm_we_q    <= dm_we_d;
            dm_wdata_q <= dm_wdata_d;
            code_err_q <= code_err_d;
        end
    end

    assign dm_we    = dm_we_q;
    assign dm_wdata = dm_wdata_q;
    assign code_err = code_err_q;

endmodule

// File: tb/tb_bus_writer.sv
// Self-checking bench for bus_writer: a reference model pushes expected
// output snapshots into a scoreboard that each test pops and compares.
module tb_bus_writer;

    logic        clk;
    logic        rst;
    logic [15:0] bus_in;
    logic [3:0]  write_en;
    logic [3:0]  inc_en;
    logic [7:0]  ar, pc, dr, r, r1, r2, ri, rj, rk;
    logic [15:0] ac, tr;
    logic        dm_we;
    logic [7:0]  dm_wdata;
    logic        code_err;

    typedef struct packed {
        logic [7:0]  ar, pc, dr, r, r1, r2, ri, rj, rk;
        logic [15:0] ac, tr;
        logic        dm_we;
        logic [7:0]  dm_wdata;
        logic        code_err;
    } snap_t;

    snap_t sbq[$];
    snap_t m;
    snap_t exp_s;
    snap_t obs_s;
    int    checks;
    int    failures;

    bus_writer #(.DATA_W(16), .REG_W(8)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in),
        .write_en(write_en), .inc_en(inc_en),
        .ar(ar), .pc(pc), .dr(dr), .r(r),
        .r1(r1), .r2(r2), .ri(ri), .rj(rj), .rk(rk),
        .ac(ac), .tr(tr), .dm_we(dm_we),
        .dm_wdata(dm_wdata), .code_err(code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t obs_snap();
        snap_t s;
        s.ar = ar; s.pc = pc; s.dr = dr; s.r = r;
        s.r1 = r1; s.r2 = r2; s.ri = ri; s.rj = rj; s.rk = rk;
        s.ac = ac; s.tr = tr; s.dm_we = dm_we;
        s.dm_wdata = dm_wdata; s.code_err = code_err;
        return s;
    endfunction

    function automatic snap_t model_next(snap_t s, logic rs,
                                         logic [3:0] we, logic [3:0] ie,
                                         logic [15:0] b);
        snap_t n;
        if (rs) return '0;
        n = s;
        n.dm_we = 1'b0;
        case (ie)
            4'd2:  n.pc = s.pc + 8'd1;
            4'd5:  n.ac = s.ac + 16'd1;
            4'd6:  n.tr = s.tr + 16'd1;
            4'd7:  n.r1 = s.r1 + 8'd1;
            4'd8:  n.r2 = s.r2 + 8'd1;
            4'd9:  n.ri = s.ri + 8'd1;
            4'd10: n.rj = s.rj + 8'd1;
            4'd11: n.rk = s.rk + 8'd1;
            default: ;
        endcase
        case (we)
            4'd1:  n.ar = b[7:0];
            4'd2:  n.pc = b[7:0];
            4'd3:  n.dr = b[7:0];
            4'd4:  n.r  = b[7:0];
            4'd5:  n.ac = b;
            4'd6:  n.tr = b;
            4'd7:  n.r1 = b[7:0];
            4'd8:  n.r2 = b[7:0];
            4'd9:  n.ri = b[7:0];
            4'd10: n.rj = b[7:0];
            4'd11: n.rk = b[7:0];
            4'd12: begin n.dm_we = 1'b1; n.dm_wdata = b[7:0]; end
            4'd13, 4'd14, 4'd15: n.code_err = 1'b1;
            default: ;
        endcase
        return n;
    endfunction

    // Drive one cycle, push the model's expectation, sample #1 after edge
    task automatic cyc(input logic rs, input logic [3:0] we,
                       input logic [3:0] ie, input logic [15:0] b);
        rst = rs; write_en = we; inc_en = ie; bus_in = b;
        m = model_next(m, rs, we, ie, b);
        sbq.push_back(m);
        @(posedge clk);
        #1;
        rst = 1'b0; write_en = 4'd0; inc_en = 4'd0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 4'd5, 4'd2, 16'hFFFF);
        exp_s = sbq.pop_front();
        obs_s = obs_snap();
        checks++;
        if (obs_s !== exp_s || obs_s !== '0) begin
            failures++;
            $display("FAIL reset obs=%h exp=%h", obs_s, exp_s);
        end
    endtask

    task automatic test_ac_write();
        cyc(1'b0, 4'd5, 4'd0, 16'hBEEF);
        exp_s = sbq.pop_front();
        obs_s = obs_snap();
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL ac_write obs=%h exp=%h", obs_s, exp_s);
        end
        checks++;
        if (ac !== 16'hBEEF) begin
            failures++;
            $display("FAIL ac_value obs=%h exp=beef", ac);
        end
    endtask

    task automatic test_trunc();
        cyc(1'b0, 4'd3, 4'd0, 16'h12AB);
        exp_s = sbq.pop_front();
        obs_s = obs_snap();
        checks++;
        if (obs_s !== exp_s || dr !== 8'hAB) begin
            failures++;
            $display("FAIL trunc dr=%h obs=%h exp=%h", dr, obs_s, exp_s);
        end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 4'd2, 4'd0, 16'h00FF);
        cyc(1'b0, 4'd0, 4'd2, 16'h0000);
        void'(sbq.pop_front());
        exp_s = sbq.pop_front();
        checks++;
        if (pc !== 8'h00 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL pc_wrap obs=%h exp=00", pc);
        end
        cyc(1'b0, 4'd5, 4'd0, 16'hFFFF);
        cyc(1'b0, 4'd0, 4'd5, 16'h1234);
        void'(sbq.pop_front());
        exp_s = sbq.pop_front();
        checks++;
        if (ac !== 16'h0000 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL ac_wrap obs=%h exp=0000", ac);
        end
    endtask

    task automatic test_same_reg();
        cyc(1'b0, 4'd7, 4'd0, 16'h0010);
        cyc(1'b0, 4'd7, 4'd7, 16'h0040);
        void'(sbq.pop_front());
        exp_s = sbq.pop_front();
        checks++;
        if (r1 !== 8'h40 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL same_reg r1=%h exp=40", r1);
        end
    endtask

    task automatic test_dual();
        cyc(1'b0, 4'd9, 4'd0, 16'h0005);
        cyc(1'b0, 4'd8, 4'd9, 16'h77A1);
        void'(sbq.pop_front());
        exp_s = sbq.pop_front();
        checks++;
        if (r2 !== 8'hA1 || ri !== 8'h06 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL dual r2=%h ri=%h exp=a1/06", r2, ri);
        end
    endtask

    task automatic test_dm();
        cyc(1'b0, 4'd12, 4'd0, 16'h0033);
        exp_s = sbq.pop_front();
        checks++;
        if (dm_we !== 1'b1 || dm_wdata !== 8'h33 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL dm_pulse we=%b wd=%h exp=1/33", dm_we, dm_wdata);
        end
        cyc(1'b0, 4'd0, 4'd0, 16'h00EE);
        exp_s = sbq.pop_front();
        checks++;
        if (dm_we !== 1'b0 || dm_wdata !== 8'h33 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL dm_hold we=%b wd=%h exp=0/33", dm_we, dm_wdata);
        end
    endtask

    task automatic test_dm_reset();
        cyc(1'b0, 4'd12, 4'd0, 16'h0055);
        cyc(1'b1, 4'd12, 4'd0, 16'h0066);
        void'(sbq.pop_front());
        exp_s = sbq.pop_front();
        obs_s = obs_snap();
        checks++;
        if (dm_we !== 1'b0 || obs_s !== exp_s || obs_s !== '0) begin
            failures++;
            $display("FAIL dm_reset obs=%h exp=%h", obs_s, exp_s);
        end
    endtask

    task automatic test_illegal();
        cyc(1'b0, 4'd1, 4'd0, 16'h0011);
        cyc(1'b0, 4'd11, 4'd0, 16'h0022);
        void'(sbq.pop_front());
        void'(sbq.pop_front());
        obs_s = obs_snap();
        cyc(1'b0, 4'd14, 4'd0, 16'hFFFF);
        exp_s = sbq.pop_front();
        checks++;
        if (code_err !== 1'b1 || obs_snap() !== exp_s ||
            obs_snap() !== (obs_s | snap_t'(1))) begin
            failures++;
            $display("FAIL illegal obs=%h exp=%h", obs_snap(), exp_s);
        end
        cyc(1'b0, 4'd0, 4'd12, 16'h0000);
        cyc(1'b0, 4'd0, 4'd3, 16'h0000);
        void'(sbq.pop_front());
        exp_s = sbq.pop_front();
        checks++;
        if (code_err !== 1'b1 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL err_sticky obs=%h exp=%h", obs_snap(), exp_s);
        end
        cyc(1'b1, 4'd0, 4'd0, 16'h0000);
        exp_s = sbq.pop_front();
        checks++;
        if (code_err !== 1'b0 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL err_clear obs=%b exp=0", code_err);
        end
    endtask

    task automatic test_nop_inc();
        cyc(1'b0, 4'd0, 4'd13, 16'h0000);
        exp_s = sbq.pop_front();
        checks++;
        if (code_err !== 1'b0 || obs_snap() !== exp_s) begin
            failures++;
            $display("FAIL inc_nop obs=%h exp=%h", obs_snap(), exp_s);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic rs;
            rs = ($urandom_range(0, 39) == 0);
            cyc(rs, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                16'($urandom));
            exp_s = sbq.pop_front();
            obs_s = obs_snap();
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL random[%0d] obs=%h exp=%h", i, obs_s, exp_s);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m = '0;
        rst = 1'b1; write_en = 4'd0; inc_en = 4'd0; bus_in = 16'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_ac_write();
        test_trunc();
        test_wrap();
        test_same_reg();
        test_dual();
        test_dm();
        test_dm_reset();
        test_illegal();
        test_nop_inc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
